riscv_mem_arbiter: RTL and testbench
====================================

Name: riscv_mem_arbiter

Overview:
Arbitrates a single-ported unified memory between the instruction-fetch port (read-only) and the MEM-stage data port (load/store). Sits between the pipeline's IF and MEM stages and the memory. Allows one outstanding transaction at a time, prevents fetch starvation, and guards against a hung memory with a response timeout.

Parameters:
WORD_SIZE, 32, address/data width
STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before the fetch wins (>=1)
TIMEOUT_CYCLES, 16, max cycles in WAIT before forced error response; 0 disables timeout

Ports:
clk_i  in  1  clock (one clock domain)
rst_i  in  1  reset, synchronous, active-high
if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o
if_addr_i  in  WORD_SIZE  fetch address
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
if_rdata_o  out  WORD_SIZE  fetch read data
if_err_o  out  1  fetch response is a timeout error (only with if_rvalid_o)
dm_req_i  in  1  data request; held with we/be/addr/wdata stable until dm_gnt_o
dm_we_i  in  1  1=store, 0=load
dm_be_i  in  WORD_SIZE/8  byte enables
dm_addr_i  in  WORD_SIZE  data address
dm_wdata_i  in  WORD_SIZE  store data
dm_gnt_o  out  1  data request accepted
dm_rvalid_o  out  1  data response valid (loads and stores)
dm_rdata_o  out  WORD_SIZE  load data
dm_err_o  out  1  data response is a timeout error
mem_req_o  out  1  request to memory
mem_we_o  out  1  write enable to memory
mem_be_o  out  WORD_SIZE/8  byte enables to memory
mem_addr_o  out  WORD_SIZE  address to memory
mem_wdata_o  out  WORD_SIZE  write data to memory
mem_gnt_i  in  1  memory accepts request
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  WORD_SIZE  memory read data
busy_o  out  1  transaction outstanding (state WAIT)

Behaviour:
- Reset (rst_i=1 at rising edge): state=IDLE, owner=DM, starve_cnt=0, tmo_cnt=0. During/after reset all outputs are 0 until a request arrives. An outstanding transaction is abandoned; no response is generated for it.
- States: IDLE, WAIT.
- IDLE: sel = IF if if_req_i && (!dm_req_i || starve_cnt==STARVE_LIMIT), else DM if dm_req_i. mem_req_o = if_req_i || dm_req_i. mem_* fields are muxed combinationally from sel. mem_we_o=0 and mem_be_o=all-ones for IF. mem_gnt_i is routed to the selected requester's gnt only; the other gnt is 0.
- Handshake: on mem_req_o && mem_gnt_i, latch owner=sel, go to WAIT, tmo_cnt=0. No gnt means stay in IDLE and re-arbitrate next cycle (requesters hold).
- Starvation: on a DM grant while if_req_i=1, starve_cnt++ (saturating at STARVE_LIMIT). On an IF grant, or whenever if_req_i=0, starve_cnt=0.
- WAIT: mem_req_o=0, all mem_* fields 0, no gnt, busy_o=1. On mem_rvalid_i: owner's rvalid_o=1, owner's rdata_o=mem_rdata_i, then go to IDLE. Earliest next grant is the following cycle, so a back-to-back transaction occupies at least 2 cycles.
- Timeout (TIMEOUT_CYCLES>0): tmo_cnt increments each WAIT cycle without rvalid. When tmo_cnt==TIMEOUT_CYCLES-1 and no rvalid: owner's rvalid_o=1 and err_o=1, rdata_o=0, go to IDLE. If rvalid and timeout coincide, rvalid wins (normal response, err=0).
- mem_rvalid_i in IDLE (spurious, or late after a timeout/reset) is ignored; no output rvalid.
- rdata_o/err_o are 0 whenever the corresponding rvalid_o=0. Responses are combinational from mem_rvalid_i/mem_rdata_i; arbitration state is registered.
- Counter widths: starve_cnt $clog2(STARVE_LIMIT+1); tmo_cnt $clog2(TIMEOUT_CYCLES+1) (min 1).

Test Plan:
- Single load: dm_req, addr=0x100, gnt at once, rvalid 3 cycles later with rdata=0xDEADBEEF -> dm_gnt_o at cycle 0, busy_o cycles 1-3, dm_rvalid_o/dm_rdata_o=0xDEADBEEF at cycle 3, if_rvalid_o never set.
- Simultaneous if_req (0x0) and dm_req store (0x200, be=0xF), 1-cycle memory -> DM granted first with mem_we_o=1; IF granted on the next IDLE cycle with mem_we_o=0, be=0xF.
- Starvation: dm_req and if_req held high continuously, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF,DM,... starve_cnt returns to 0 after the IF grant.
- Timeout: grant IF, never assert rvalid, TIMEOUT_CYCLES=16 -> if_rvalid_o=1 and if_err_o=1 on the 16th WAIT cycle, back to IDLE. A late mem_rvalid_i 2 cycles later is ignored.
- Reset mid-WAIT: rst_i=1 for 1 cycle while waiting on a DM load -> IDLE, busy_o=0, no dm_rvalid_o for the abandoned load, and the next request arbitrates normally.
- mem_gnt_i held low 5 cycles with dm_req pending -> mem_req_o stays 1 with stable address, dm_gnt_o only in the cycle mem_gnt_i=1.

Source files
------------

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the
// single-ported unified memory. The arbiter uses the slave view; the
// surrounding pipeline/memory environment uses the master view.
interface riscv_mem_arbiter_if #(
   parameter int WORD_SIZE = 32
);
   // fetch port
   logic                   if_req_i;
   logic [WORD_SIZE-1:0]   if_addr_i;
   logic                   if_gnt_o;
   logic                   if_rvalid_o;
   logic [WORD_SIZE-1:0]   if_rdata_o;
   logic                   if_err_o;
   // data port
   logic                   dm_req_i;
   logic                   dm_we_i;
   logic [WORD_SIZE/8-1:0] dm_be_i;
   logic [WORD_SIZE-1:0]   dm_addr_i;
   logic [WORD_SIZE-1:0]   dm_wdata_i;
   logic                   dm_gnt_o;
   logic                   dm_rvalid_o;
   logic [WORD_SIZE-1:0]   dm_rdata_o;
   logic                   dm_err_o;
   // memory port
   logic                   mem_req_o;
   logic                   mem_we_o;
   logic [WORD_SIZE/8-1:0] mem_be_o;
   logic [WORD_SIZE-1:0]   mem_addr_o;
   logic [WORD_SIZE-1:0]   mem_wdata_o;
   logic                   mem_gnt_i;
   logic                   mem_rvalid_i;
   logic [WORD_SIZE-1:0]   mem_rdata_i;
   // status
   logic                   busy_o;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
      input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
      output dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output busy_o
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
      output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
      input  dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  busy_o
   );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter for a unified memory shared by instruction
// fetch and the MEM-stage data port. Data normally wins, but a fetch that
// has waited through STARVE_LIMIT data grants is served next. A hung
// memory is released after TIMEOUT_CYCLES with an error response.
//
// state  | meaning
// S_IDLE | no transaction outstanding; arbitrate and offer request to memory
// S_WAIT | one transaction accepted by memory; waiting for its response
module riscv_mem_arbiter #(
   parameter int WORD_SIZE      = 32,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic              clk_i,
   input logic              rst_i,
   riscv_mem_arbiter_if.slave bus
);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam int TMO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit TMO_EN   = (TIMEOUT_CYCLES > 0);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
   localparam logic [TMO_W-1:0]    TMO_LAST   =
      TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic {S_IDLE, S_WAIT} state_t;
   typedef enum logic {OWN_DM, OWN_IF} owner_t;

   state_t                r_state;
   owner_t                r_owner;
   logic [STARVE_W-1:0]   r_starve_cnt;
   logic [TMO_W-1:0]      r_tmo_cnt;

   logic                  w_idle;
   logic                  w_wait;
   logic                  w_any_req;
   logic                  w_sel_if;
   logic                  w_hs;
   logic                  w_if_gnt;
   logic                  w_dm_gnt;
   logic                  w_tmo;
   logic                  w_resp;
   logic                  w_resp_if;
   logic                  w_resp_dm;
   logic [WORD_SIZE-1:0]  w_resp_data;

   // Outputs are forced quiet while reset is asserted, so a transaction
   // abandoned by reset can never produce a response or a grant.
   assign w_idle    = (r_state == S_IDLE) && !rst_i;
   assign w_wait    = (r_state == S_WAIT) && !rst_i;
   assign w_any_req = bus.if_req_i || bus.dm_req_i;
   assign w_sel_if  = bus.if_req_i && (!bus.dm_req_i || (r_starve_cnt == STARVE_MAX));
   assign w_hs      = w_idle && w_any_req && bus.mem_gnt_i;
   assign w_if_gnt  = w_hs && w_sel_if;
   assign w_dm_gnt  = w_hs && !w_sel_if;

   // A real response arriving on the last allowed cycle beats the timeout.
   assign w_tmo       = TMO_EN && w_wait && !bus.mem_rvalid_i && (r_tmo_cnt == TMO_LAST);
   assign w_resp      = w_wait && (bus.mem_rvalid_i || w_tmo);
   assign w_resp_if   = w_resp && (r_owner == OWN_IF);
   assign w_resp_dm   = w_resp && (r_owner == OWN_DM);
   assign w_resp_data = bus.mem_rvalid_i ? bus.mem_rdata_i : '0;

   assign bus.if_gnt_o    = w_if_gnt;
   assign bus.dm_gnt_o    = w_dm_gnt;
   assign bus.if_rvalid_o = w_resp_if;
   assign bus.if_rdata_o  = w_resp_if ? w_resp_data : '0;
   assign bus.if_err_o    = w_resp_if && w_tmo;
   assign bus.dm_rvalid_o = w_resp_dm;
   assign bus.dm_rdata_o  = w_resp_dm ? w_resp_data : '0;
   assign bus.dm_err_o    = w_resp_dm && w_tmo;
   assign bus.busy_o      = w_wait;

   // Present the selected requester to memory; fetch is a full-word read.
   always_comb begin
      bus.mem_req_o   = 1'b0;
      bus.mem_we_o    = 1'b0;
      bus.mem_be_o    = '0;
      bus.mem_addr_o  = '0;
      bus.mem_wdata_o = '0;
      if (w_idle && w_any_req) begin
         bus.mem_req_o = 1'b1;
         if (w_sel_if) begin
            bus.mem_be_o   = '1;
            bus.mem_addr_o = bus.if_addr_i;
         end else begin
            bus.mem_we_o    = bus.dm_we_i;
            bus.mem_be_o    = bus.dm_be_i;
            bus.mem_addr_o  = bus.dm_addr_i;
            bus.mem_wdata_o = bus.dm_wdata_i;
         end
      end
   end

   // Arbitration state, response timer and fetch-starvation counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_owner      <= OWN_DM;
         r_starve_cnt <= '0;
         r_tmo_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_state   <= S_WAIT;
                  r_owner   <= w_sel_if ? OWN_IF : OWN_DM;
                  r_tmo_cnt <= '0;
               end
            end
            S_WAIT: begin
               if (w_resp) begin
                  r_state <= S_IDLE;
               end else if (TMO_EN) begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (!bus.if_req_i || w_if_gnt) begin
            r_starve_cnt <= '0;
         end else if (w_dm_gnt && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized bench: a transaction-level model of the two requesters and the
// memory predicts grants, bus contents and responses; a negedge monitor pops
// the expectations whenever the DUT shows an event.
module tb_riscv_mem_arbiter;
   localparam int WS    = 32;
   localparam int SL    = 4;
   localparam int TMO   = 16;
   localparam int N_CYC = 4000;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   riscv_mem_arbiter_if #(.WORD_SIZE(WS)) bus ();

   riscv_mem_arbiter #(
      .WORD_SIZE(WS), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus  (bus)
   );

   typedef struct {
      logic        busy;
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
   } cyc_t;
   typedef struct { logic is_if; logic [31:0] wdata; } gnt_t;
   typedef struct { logic is_if; logic [31:0] data; logic err; } rsp_t;

   cyc_t cyc_q[$];
   gnt_t gnt_q[$];
   rsp_t rsp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   // model state: pending requests, memory transaction, fetch wait count
   bit          if_pend, dm_pend;
   logic [31:0] if_addr_m, dm_addr_m, dm_wdata_m;
   logic        dm_we_m;
   logic [3:0]  dm_be_m;
   bit          m_busy, m_own_if, rst_pending;
   int          m_starve, m_wait, m_lat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // 0 means the memory never answers for this transaction
   function automatic int pick_lat();
      int r;
      r = $urandom_range(99);
      if (r < 8)  return 0;
      if (r < 12) return TMO;
      if (r < 15) return TMO - 1;
      return $urandom_range(4, 1);
   endfunction

   task automatic step();
      cyc_t c;
      gnt_t g;
      rsp_t r;
      bit   ifr, any, pick_if;
      if (!if_pend && $urandom_range(99) < 45) begin
         if_pend   = 1'b1;
         if_addr_m = $urandom() & 32'hFFFF_FFFC;
      end
      if (!dm_pend && $urandom_range(99) < 70) begin
         dm_pend    = 1'b1;
         dm_we_m    = 1'($urandom_range(1));
         dm_be_m    = 4'($urandom_range(15, 1));
         dm_addr_m  = $urandom();
         dm_wdata_m = $urandom();
      end
      bus.if_req_i   = if_pend;
      bus.if_addr_i  = if_addr_m;
      bus.dm_req_i   = dm_pend;
      bus.dm_we_i    = dm_we_m;
      bus.dm_be_i    = dm_be_m;
      bus.dm_addr_i  = dm_addr_m;
      bus.dm_wdata_i = dm_wdata_m;
      bus.mem_rdata_i = $urandom();
      bus.mem_gnt_i   = ($urandom_range(99) < 70);
      ifr = if_pend;
      c = '{busy: 1'b0, req: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h0};

      if (rst_pending && m_busy) begin
         rst_i            = 1'b1;
         bus.mem_rvalid_i = 1'b1;
         cyc_q.push_back(c);
         m_busy      = 1'b0;
         m_starve    = 0;
         rst_pending = 1'b0;
         return;
      end
      rst_i = 1'b0;

      if (!m_busy) begin
         bus.mem_rvalid_i = ($urandom_range(99) < 10);
         any     = if_pend || dm_pend;
         pick_if = if_pend && (!dm_pend || m_starve >= SL);
         c.req   = any;
         if (any && pick_if) begin
            c.addr = if_addr_m;
            c.be   = 4'hF;
         end else if (any) begin
            c.addr = dm_addr_m;
            c.be   = dm_be_m;
            c.we   = dm_we_m;
         end
         cyc_q.push_back(c);
         if (any && bus.mem_gnt_i) begin
            g.is_if = pick_if;
            g.wdata = pick_if ? 32'h0 : dm_wdata_m;
            gnt_q.push_back(g);
            m_busy   = 1'b1;
            m_own_if = pick_if;
            m_wait   = 0;
            m_lat    = pick_lat();
            if (pick_if) begin
               if_pend  = 1'b0;
               m_starve = 0;
            end else begin
               dm_pend = 1'b0;
               if (ifr && m_starve < SL) m_starve++;
            end
         end
         if (!ifr) m_starve = 0;
      end else begin
         m_wait++;
         bus.mem_rvalid_i = (m_wait == m_lat);
         c.busy = 1'b1;
         cyc_q.push_back(c);
         if (bus.mem_rvalid_i) begin
            r = '{is_if: m_own_if, data: bus.mem_rdata_i, err: 1'b0};
            rsp_q.push_back(r);
            m_busy = 1'b0;
         end else if (m_wait == TMO) begin
            r = '{is_if: m_own_if, data: 32'h0, err: 1'b1};
            rsp_q.push_back(r);
            m_busy = 1'b0;
         end
         if (!ifr) m_starve = 0;
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk_i) begin
      cyc_t c;
      gnt_t g;
      rsp_t r;
      if (mon_en) begin
         if (cyc_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL cycle_sync: got monitor cycle expected a driven cycle at %0t", $time);
         end else begin
            c = cyc_q.pop_front();
            chk("busy_o",     32'(bus.busy_o),    32'(c.busy));
            chk("mem_req_o",  32'(bus.mem_req_o), 32'(c.req));
            chk("mem_we_o",   32'(bus.mem_we_o),  32'(c.we));
            chk("mem_be_o",   32'(bus.mem_be_o),  32'(c.be));
            chk("mem_addr_o", bus.mem_addr_o,     c.addr);
         end
         if (bus.if_gnt_o || bus.dm_gnt_o) begin
            if (gnt_q.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL unexpected_gnt: got if=%0b dm=%0b expected none at %0t",
                        bus.if_gnt_o, bus.dm_gnt_o, $time);
            end else begin
               g = gnt_q.pop_front();
               chk("if_gnt_o", 32'(bus.if_gnt_o), 32'(g.is_if));
               chk("dm_gnt_o", 32'(bus.dm_gnt_o), 32'(!g.is_if));
               if (!g.is_if) chk("mem_wdata_o", bus.mem_wdata_o, g.wdata);
            end
         end
         if (bus.if_rvalid_o || bus.dm_rvalid_o) begin
            if (rsp_q.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL unexpected_rsp: got if=%0b dm=%0b expected none at %0t",
                        bus.if_rvalid_o, bus.dm_rvalid_o, $time);
            end else begin
               r = rsp_q.pop_front();
               chk("if_rvalid_o", 32'(bus.if_rvalid_o), 32'(r.is_if));
               chk("dm_rvalid_o", 32'(bus.dm_rvalid_o), 32'(!r.is_if));
               chk("rsp_rdata", r.is_if ? bus.if_rdata_o : bus.dm_rdata_o, r.data);
               chk("rsp_err", 32'(r.is_if ? bus.if_err_o : bus.dm_err_o), 32'(r.err));
            end
         end
         if (!bus.if_rvalid_o) begin
            chk("if_rdata_quiet", bus.if_rdata_o, 32'h0);
            chk("if_err_quiet", 32'(bus.if_err_o), 32'h0);
         end
         if (!bus.dm_rvalid_o) begin
            chk("dm_rdata_quiet", bus.dm_rdata_o, 32'h0);
            chk("dm_err_quiet", 32'(bus.dm_err_o), 32'h0);
         end
      end
   end

   initial begin
      cyc_t z;
      z = '{busy: 1'b0, req: 1'b0, we: 1'b0, be: 4'h0, addr: 32'h0};
      bus.if_req_i = 1'b0;  bus.if_addr_i = '0;
      bus.dm_req_i = 1'b0;  bus.dm_we_i = 1'b0; bus.dm_be_i = '0;
      bus.dm_addr_i = '0;   bus.dm_wdata_i = '0;
      bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
      if_pend = 1'b0; dm_pend = 1'b0; m_busy = 1'b0; m_own_if = 1'b0;
      rst_pending = 1'b0; m_starve = 0; m_wait = 0; m_lat = 0;
      if_addr_m = '0; dm_addr_m = '0; dm_wdata_m = '0; dm_we_m = 1'b0; dm_be_m = '0;
      rst_i = 1'b1;
      repeat (3) begin
         @(posedge clk_i); #1;
         cyc_q.push_back(z);
         mon_en = 1'b1;
      end
      for (int i = 0; i < N_CYC; i++) begin
         @(posedge clk_i); #1;
         if (i % 700 == 350) rst_pending = 1'b1;
         step();
      end
      @(negedge clk_i); #1;
      mon_en = 1'b0;
      chk("gnt_q_drained", 32'(gnt_q.size()), 32'h0);
      chk("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
      chk("cyc_q_drained", 32'(cyc_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
